// File: rtl/displays_multicanal.sv
// Time-multiplexed binary-to-7-segment driver: one double-dabble engine converts
// each channel in turn, with leading-zero blanking, overflow dashes and blinking.
module displays_multicanal #(
  parameter int unsigned NCH       = 3,
  parameter int unsigned BIN_W     = 7,
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NCH*BIN_W-1:0]      count_bus_i,
  input  logic                      blank_zero_i,
  input  logic [NCH-1:0]            blink_mask_i,
  output logic [NCH*DIGITS*7-1:0]   hex_bus_o,
  output logic                      frame_done_o
);

  localparam int unsigned ChW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BitW   = $clog2(BIN_W + 1);
  localparam int unsigned BlkW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned BcdW   = DIGITS * 4;
  localparam int unsigned SegW   = DIGITS * 7;
  localparam int unsigned CmpW   = (BIN_W > 14) ? BIN_W : 14;
  localparam int unsigned MaxVal = 10 ** DIGITS - 1;

  typedef enum logic [1:0] {StLoad, StShift, StWrite} state_e;

  state_e                  state_q;
  logic [ChW-1:0]          ch_q;
  logic [BitW-1:0]         bit_cnt_q;
  logic [BIN_W-1:0]        bin_q;
  logic [BcdW-1:0]         bcd_q;
  logic                    ovf_q;
  logic [NCH*SegW-1:0]     seg_q;
  logic                    frame_done_q;
  logic [BlkW-1:0]         blink_cnt_q;
  logic                    phase_q;

  logic [BIN_W-1:0]        cur_cnt;
  logic [BcdW-1:0]         bcd_adj;
  logic [SegW-1:0]         enc;
  logic [3:0]              nib;
  logic                    lead_zero;

  function automatic logic [6:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 7'h40;
      4'd1:    seg_lut = 7'h79;
      4'd2:    seg_lut = 7'h24;
      4'd3:    seg_lut = 7'h30;
      4'd4:    seg_lut = 7'h19;
      4'd5:    seg_lut = 7'h12;
      4'd6:    seg_lut = 7'h02;
      4'd7:    seg_lut = 7'h78;
      4'd8:    seg_lut = 7'h00;
      4'd9:    seg_lut = 7'h10;
      default: seg_lut = 7'h7F;
    endcase
  endfunction

  always_comb begin
    cur_cnt = count_bus_i[ch_q*BIN_W +: BIN_W];
    for (int i = 0; i < DIGITS; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    // Walk from the most significant digit so lead_zero covers all higher digits.
    enc       = '1;
    nib       = '0;
    lead_zero = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      nib       = bcd_q[d*4 +: 4];
      lead_zero = lead_zero & (nib == 4'd0);
      if (ovf_q) begin
        enc[d*7 +: 7] = 7'h3F;
      end else if (blank_zero_i && (d != 0) && lead_zero) begin
        enc[d*7 +: 7] = 7'h7F;
      end else begin
        enc[d*7 +: 7] = seg_lut(nib);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StLoad;
      ch_q         <= '0;
      bit_cnt_q    <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      ovf_q        <= 1'b0;
      seg_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        StLoad: begin
          bin_q     <= cur_cnt;
          bcd_q     <= '0;
          ovf_q     <= CmpW'(cur_cnt) > CmpW'(MaxVal);
          bit_cnt_q <= '0;
          state_q   <= StShift;
        end
        StShift: begin
          {bcd_q, bin_q} <= {bcd_adj[BcdW-2:0], bin_q, 1'b0};
          if (bit_cnt_q == BitW'(BIN_W - 1)) begin
            bit_cnt_q <= '0;
            state_q   <= StWrite;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        StWrite: begin
          seg_q[ch_q*SegW +: SegW] <= enc;
          if (ch_q == ChW'(NCH - 1)) begin
            ch_q         <= '0;
            frame_done_q <= 1'b1;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
          state_q <= StLoad;
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else if (blink_cnt_q == BlkW'(BLINK_DIV - 1)) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      hex_bus_o[c*SegW +: SegW] = (blink_mask_i[c] && !phase_q) ? {SegW{1'b1}}
                                                                 : seg_q[c*SegW +: SegW];
    end
  end

  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_displays_multicanal.sv
// Scoreboard bench for displays_multicanal: per-frame expected patterns are queued by
// the stimulus process and checked by an independent monitor on each FRAME_DONE.
module tb_displays_multicanal;
  localparam int unsigned NCH   = 3;
  localparam int unsigned BW    = 7;
  localparam int unsigned DG    = 2;
  localparam int unsigned BD    = 4;
  localparam int unsigned FRAME = NCH * (BW + 2);
  localparam int unsigned NENT  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH*BW-1:0]   count_bus = '0;
  logic                blank_zero = 1'b0;
  logic [NCH-1:0]      blink_mask = '0;
  logic [NCH*DG*7-1:0] hex_bus;
  logic                frame_done;

  logic [39:0]         count4 = {10'd999, 10'd5, 10'd300, 10'd42};
  logic                blank4 = 1'b0;
  logic [3:0]          mask4 = 4'b0000;
  logic [83:0]         hex4;
  logic                frame_done4;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit sb_en = 1'b0;
  bit done4 = 1'b0;

  typedef struct packed {
    logic [NCH*BW-1:0] cnt;
    logic              blank;
    logic [NCH-1:0]    mask;
  } ent_t;

  ent_t exp_q[$];

  displays_multicanal #(.NCH(NCH), .BIN_W(BW), .DIGITS(DG), .BLINK_DIV(BD)) u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .count_bus_i  (count_bus),
    .blank_zero_i (blank_zero),
    .blink_mask_i (blink_mask),
    .hex_bus_o    (hex_bus),
    .frame_done_o (frame_done)
  );

  displays_multicanal #(.NCH(4), .BIN_W(10), .DIGITS(3), .BLINK_DIV(BD)) u_dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .count_bus_i  (count4),
    .blank_zero_i (blank4),
    .blink_mask_i (mask4),
    .hex_bus_o    (hex4),
    .frame_done_o (frame_done4)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal reference: digit d = (v / 10^d) % 10, blanked when v < 10^d.
  function automatic logic [127:0] enc_ch(input int v, input int digits, input bit blank);
    logic [127:0] r;
    int pw;
    r = '1;
    pw = 1;
    for (int d = 0; d < digits; d++) begin
      if (v > 10 ** digits - 1)          r[d*7 +: 7] = 7'h3F;
      else if (blank && d >= 1 && v < pw) r[d*7 +: 7] = 7'h7F;
      else                                r[d*7 +: 7] = seg7((v / pw) % 10);
      pw = pw * 10;
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_bus(input ent_t e, input int n);
    logic [127:0] r;
    logic [127:0] ch;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      ch = enc_ch(int'(e.cnt[c*BW +: BW]), DG, e.blank);
      if (e.mask[c] && ((n / BD) % 2 == 1)) r[c*DG*7 +: DG*7] = {DG*7{1'b1}};
      else                                  r[c*DG*7 +: DG*7] = ch[DG*7-1:0];
    end
    return r;
  endfunction

  function automatic ent_t mk(input int a, input int b, input int c, input bit bl,
                              input logic [2:0] m);
    ent_t e;
    e.cnt   = {7'(c), 7'(b), 7'(a)};
    e.blank = bl;
    e.mask  = m;
    return e;
  endfunction

  task automatic apply(input ent_t e);
    count_bus  = e.cnt;
    blank_zero = e.blank;
    blink_mask = e.mask;
    exp_q.push_back(e);
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_timeout: got no FRAME_DONE want one within %0d cycles", 2 * FRAME);
    end
  endtask

  initial begin : monitor
    int   next_fd;
    ent_t e;
    next_fd = FRAME;
    forever begin
      @(negedge clk);
      if (sb_en && !rst) begin
        if (frame_done) begin
          chk("fd_period", 128'(cyc), 128'(next_fd));
          next_fd += FRAME;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got FRAME_DONE want none (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("frame_hex", 128'(hex_bus), exp_bus(e, cyc));
          end
        end else if (cyc >= next_fd) begin
          n_cmp++;
          n_err++;
          $display("FAIL fd_missing: got 0 want 1 (cycle %0d)", cyc);
          next_fd += FRAME;
        end
      end
    end
  end

  initial begin : inst4_check
    logic [127:0] r;
    wait (!rst);
    wait (cyc == 47);
    @(negedge clk);
    chk("w3_ch3_dark_before_48", 128'(hex4[83:63]), 128'(21'h1FFFFF));
    @(posedge clk);
    @(negedge clk);
    r = enc_ch(999, 3, 1'b0);
    chk("w3_ch3_999", 128'(hex4[83:63]), 128'(r[20:0]));
    #2 count4[39:30] = 10'd1000;
    wait (cyc == 96);
    @(negedge clk);
    r = enc_ch(1000, 3, 1'b0);
    chk("w3_ch3_1000_ovf", 128'(hex4[83:63]), 128'(r[20:0]));
    done4 = 1'b1;
  end

  initial begin : main
    ent_t         dir [6];
    ent_t         e;
    bit           ok;
    logic [127:0] r;
    dir[0] = mk(99, 10, 12, 1'b0, 3'b000);
    dir[1] = mk(127, 5, 12, 1'b1, 3'b000);
    dir[2] = mk(98, 5, 12, 1'b0, 3'b000);
    dir[3] = mk(98, 0, 12, 1'b1, 3'b000);
    dir[4] = mk(98, 5, 12, 1'b0, 3'b010);
    dir[5] = mk(98, 5, 0, 1'b1, 3'b010);

    apply(dir[0]);
    sb_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hex", 128'(hex_bus), 128'({NCH*DG*7{1'b1}}));
    chk("reset_fd", 128'(frame_done), 128'(0));
    chk("reset_hex4", 128'(hex4), 128'({84{1'b1}}));
    @(negedge clk);
    rst = 1'b0;

    repeat (26) @(posedge clk);
    @(negedge clk);
    chk("ch2_dark_before_27", 128'(hex_bus[41:28]), 128'(14'h3FFF));

    for (int k = 1; k < NENT; k++) begin
      wait_frame(ok);
      if (!ok) break;
      #2;
      if (k < 6) begin
        apply(dir[k]);
      end else begin
        e = mk(int'($urandom_range(0, 127)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
               3'($urandom_range(0, 7)));
        apply(e);
      end
    end

    for (int i = 0; i < 4 * FRAME && exp_q.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));
    sb_en = 1'b0;
    chk("inst4_done", 128'(done4), 128'(1));

    // Reset in the middle of channel 1's shift phase.
    wait_frame(ok);
    #2;
    count_bus  = {7'd12, 7'd73, 7'd42};
    blank_zero = 1'b0;
    blink_mask = '0;
    repeat (12) @(posedge clk);
    #1;
    r = enc_ch(42, DG, 1'b0);
    chk("pre_rst_ch0", 128'(hex_bus[13:0]), 128'(r[13:0]));
    rst = 1'b1;
    #1;
    chk("mid_rst_hex", 128'(hex_bus), 128'({NCH*DG*7{1'b1}}));
    chk("mid_rst_fd", 128'(frame_done), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst_ch0_dark_e8", 128'(hex_bus[13:0]), 128'(14'h3FFF));
    @(posedge clk);
    @(negedge clk);
    chk("rst_ch0_e9", 128'(hex_bus[13:0]), 128'(r[13:0]));
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("rst_ch1_dark_e17", 128'(hex_bus[27:14]), 128'(14'h3FFF));
    @(posedge clk);
    @(negedge clk);
    r = enc_ch(73, DG, 1'b0);
    chk("rst_ch1_e18", 128'(hex_bus[27:14]), 128'(r[13:0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end want finish by 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/displays_multicanal.md
# displays_multicanal

Parametrised, time-multiplexed binary-to-7-segment display driver for the bottling-line counters (bottles, dozens, corks and future channels). A single iterative double-dabble engine converts each channel in round-robin order and stores the segment patterns in output registers. Adds leading-zero blanking, overflow indication and per-channel blinking. It sits between the counter blocks and the board HEX pins and replaces one combinational converter and decoder pair per display.

## Interface
- NCH, 3: number of counter channels (≥1)
- BIN_W, 7: width of each binary count (≥1)
- DIGITS, 2: decimal digits per channel (1–4)
- BLINK_DIV, 25000000: clock cycles per blink half-period (≥1)
- CLK  in  1: system clock, all state on rising edge
- RST  in  1: asynchronous, active-high reset
- COUNT_BUS  in  NCH*BIN_W: channel c at [c*BIN_W +: BIN_W], unsigned
- BLANK_ZERO  in  1: 1 = blank leading zero digits
- BLINK_MASK  in  NCH: bit c = 1 makes channel c blink
- HEX_BUS  out  NCH*DIGITS*7: digit d of channel c at [(c*DIGITS+d)*7 +: 7]; d=0 is units; bit order gfedcba, active-low
- FRAME_DONE  out  1: one-cycle pulse when the last channel of a sweep is written

## Operation
- Segment codes (active-low gfedcba): 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h, blank=7Fh, dash=3Fh.
- FSM states LOAD, SHIFT and WRITE, plus a channel index CH (0..NCH-1).
  - LOAD (1 cycle): latch COUNT_BUS channel CH into the binary shift register and clear the DIGITS*4-bit BCD register. Set OVF = (value > 10^DIGITS − 1). Go to SHIFT.
  - SHIFT (BIN_W cycles, bit counter): add 3 to every BCD nibble ≥ 5, then shift {BCD, BIN} left by 1. After the BIN_W-th shift, go to WRITE.
  - WRITE (1 cycle): encode the nibbles and write them to channel CH's segment registers. If CH = NCH−1, pulse FRAME_DONE and set CH to 0; otherwise increment CH. Go to LOAD.
- Encoding rules:
  - If OVF = 1, all digits of the channel show dash. BCD content is ignored, so BCD truncation when DIGITS*4 is narrower than needed is harmless.
  - If BLANK_ZERO = 1, digit d (d ≥ 1) is blank when it and all higher digits are zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Blink:
  - A free-running counter runs 0..BLINK_DIV−1. PHASE toggles when the counter wraps.
  - HEX_BUS is the segment register forced to 7Fh for channel c when BLINK_MASK[c] = 1 and PHASE = 0. This gating is combinational on the registered values.
- COUNT_BUS is sampled only in LOAD. Changes during SHIFT and WRITE affect the next conversion of that channel only.
- BLANK_ZERO is sampled in WRITE.

## Timing
- Reset values:
  - FSM = LOAD, CH = 0, bit counter = 0.
  - All segment registers = 7Fh (all displays dark), so HEX_BUS is all ones.
  - FRAME_DONE = 0, blink counter = 0, PHASE = 1 (visible).
- Per-channel latency is BIN_W+2 cycles. For the first sweep after reset release:
  - First LOAD at edge 1.
  - Channel c segment registers update at edge (c+1)*(BIN_W+2).
  - FRAME_DONE is high for the cycle following edge NCH*(BIN_W+2).
- Defaults give 9 cycles per channel and a 27-cycle frame.
- Steady state: each channel refreshes exactly every NCH*(BIN_W+2) cycles and FRAME_DONE pulses with that period.
- Worst-case input-to-display latency is 2*NCH*(BIN_W+2) − 1 cycles.
- Reset asserted mid-conversion aborts immediately. Partial results are discarded, outputs go dark, and after release the sweep restarts at channel 0.
- BLINK_MASK change is visible on HEX_BUS in the same cycle.
- With NCH = 1, CH stays 0 and FRAME_DONE pulses every BIN_W+2 cycles.

## Test plan
- Defaults, COUNT_BUS channel values {0:99, 1:10, 2:12}, BLANK_ZERO=0 → channel 2 (value 12) outputs exactly as follows:
  - Before edge 27: HEX_BUS all 7Fh.
  - From edge 27: digit1 = 79h, digit0 = 24h.
  - FRAME_DONE high exactly one cycle after edge 27, then every 27 cycles.
- Channel 0 = 127 (overflow) → both channel 0 digits = 3Fh. Then set channel 0 = 98 → within ≤53 cycles, digit1 = 10h, digit0 = 00h.
- Channel 1 = 5:
  - BLANK_ZERO=1 → digit1 = 7Fh, digit0 = 12h.
  - BLANK_ZERO=0 → digit1 = 40h.
  - Value 0 with BLANK_ZERO=1 → digit1 = 7Fh, digit0 = 40h.
- BLINK_DIV=4, BLINK_MASK=3'b010, all channels stable → channel 1 digits alternate between the decoded pattern and 7Fh every 4 cycles, starting visible. Channels 0 and 2 are never blanked.
- RST pulsed during SHIFT of channel 1 → HEX_BUS = all 7Fh asynchronously and FRAME_DONE = 0. After release, channel 0 updates at edge 9 and channel 1 at edge 18.
- NCH=4, BIN_W=10, DIGITS=3, channel 3 = 999 → all three digits = 10h at edge 48. Channel 3 = 1000 → all three digits = 3Fh.
